// File: rtl/rtc_data_sequencer_if.sv
// ----------------------------------------------------------------------------
// rtc_data_sequencer_if
// Word handshake between the RTC data sequencer and the RTC bus controller.
//   bus_req     : a word is valid (sequencer -> controller)
//   bus_ack     : controller accepts the current word (controller -> sequencer)
//   bus_is_addr : 1 = address word, 0 = data word
//   bus_data    : the word itself
// A word moves on a rising edge where bus_req and bus_ack are both high.
// ----------------------------------------------------------------------------
interface rtc_data_sequencer_if #(
    parameter int DATA_W = 8
) ();
    logic              bus_req;
    logic              bus_ack;
    logic              bus_is_addr;
    logic [DATA_W-1:0] bus_data;

    // Sequencer side
    modport master (
        output bus_req,
        output bus_is_addr,
        output bus_data,
        input  bus_ack
    );

    // Bus controller side
    modport slave (
        input  bus_req,
        input  bus_is_addr,
        input  bus_data,
        output bus_ack
    );
endinterface

// File: rtl/rtc_data_sequencer.sv
// ----------------------------------------------------------------------------
// rtc_data_sequencer
// Takes a snapshot of N_CH RTC register address/value pairs on start and
// pushes every enabled channel to the RTC bus controller as an address word
// followed by a data word, honouring back-pressure from the controller.
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : request a sweep (only looked at while idle)
//   abort        : cancel a sweep in progress, no done pulse
//   ch_mask      : per-channel enable, bit i = channel i
//   ch_addr      : packed register addresses, channel i at [i*DATA_W +: DATA_W]
//   ch_data      : packed register values, same packing
//   bus          : word handshake toward the bus controller (master side)
//   band         : index of the channel currently being transferred
//   busy         : high whenever the sequencer is not idle
//   done         : one-cycle pulse when a sweep completes normally
// ----------------------------------------------------------------------------
module rtc_data_sequencer #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 6,
    parameter int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [N_CH*DATA_W-1:0] ch_addr,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    rtc_data_sequencer_if.master   bus,
    output logic [IDX_W-1:0]       band,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   snap_mask_q, snap_mask_d;
    logic [DATA_W-1:0] snap_addr_q [N_CH];
    logic [DATA_W-1:0] snap_addr_d [N_CH];
    logic [DATA_W-1:0] snap_data_q [N_CH];
    logic [DATA_W-1:0] snap_data_d [N_CH];
    // One extra bit so the pointer can sit at N_CH after the last channel
    // and the scan then finds nothing instead of wrapping around.
    logic [IDX_W:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]  band_q, band_d;

    logic              found;
    logic [IDX_W-1:0]  found_idx;

    // Lowest enabled snapshot channel at or above the scan pointer. The loop
    // walks downward so the last hit written is the lowest index.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (snap_mask_q[i] && (i >= int'(ptr_q))) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic. abort outranks bus_ack, so a word acknowledged on the
    // abort edge is simply dropped by this block.
    always_comb begin
        state_d     = state_q;
        snap_mask_d = snap_mask_q;
        snap_addr_d = snap_addr_q;
        snap_data_d = snap_data_q;
        ptr_d       = ptr_q;
        band_d      = band_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_mask_d = ch_mask;
                    for (int i = 0; i < N_CH; i++) begin
                        snap_addr_d[i] = ch_addr[i*DATA_W +: DATA_W];
                        snap_data_d[i] = ch_data[i*DATA_W +: DATA_W];
                    end
                    ptr_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (found) begin
                    band_d  = found_idx;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ADDR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bus.bus_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bus.bus_ack) begin
                    ptr_d   = {1'b0, band_q} + {{IDX_W{1'b0}}, 1'b1};
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and snapshot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            snap_mask_q <= '0;
            ptr_q       <= '0;
            band_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                snap_addr_q[i] <= '0;
                snap_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            snap_mask_q <= snap_mask_d;
            ptr_q       <= ptr_d;
            band_q      <= band_d;
            snap_addr_q <= snap_addr_d;
            snap_data_q <= snap_data_d;
        end
    end

    // Outputs are decoded purely from registered state, so nothing on the
    // input side can ripple through to the bus in the same cycle.
    always_comb begin
        bus.bus_req     = 1'b0;
        bus.bus_is_addr = 1'b0;
        bus.bus_data    = '0;
        case (state_q)
            ST_ADDR: begin
                bus.bus_req     = 1'b1;
                bus.bus_is_addr = 1'b1;
                bus.bus_data    = snap_addr_q[band_q];
            end
            ST_DATA: begin
                bus.bus_req  = 1'b1;
                bus.bus_data = snap_data_q[band_q];
            end
            default: begin
                bus.bus_req = 1'b0;
            end
        endcase
    end

    assign band = band_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_rtc_data_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rtc_data_sequencer
// Drives sweep scenarios from a table of records and checks the captured word
// stream, done timing, idle behaviour and back-pressure stability against
// hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_rtc_data_sequencer;

    localparam int DATA_W = 8;
    localparam int N_CH   = 6;
    localparam int IDX_W  = 3;
    localparam int WINDOW = 32;

    typedef struct {
        string       name;
        logic [5:0]  mask;
        int          stall_at;
        int          stall_len;
        logic [7:0]  stall_word;
        int          poke_at;
        int          abort_at;
        int          reset_at;
        int          exp_words;
        int          exp_done;
        int          idle_at;
        logic        all_zero;
        logic [31:0] req_low;
    } vec_t;

    typedef struct packed {
        logic       is_addr;
        logic [7:0] data;
        logic [2:0] band;
    } word_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   abort;
    logic [N_CH-1:0]        ch_mask;
    logic [N_CH*DATA_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [IDX_W-1:0]       band;
    logic                   busy;
    logic                   done;

    rtc_data_sequencer_if #(.DATA_W(DATA_W)) bus ();

    rtc_data_sequencer #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .ch_mask (ch_mask),
        .ch_addr (ch_addr),
        .ch_data (ch_data),
        .bus     (bus.master),
        .band    (band),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int e_cyc      = 0;
    int mon_r;
    logic armed = 1'b0;

    logic       req_hist  [64];
    logic       addr_hist [64];
    logic [7:0] data_hist [64];
    logic [2:0] band_hist [64];
    logic       busy_hist [64];
    logic       done_hist [64];
    word_t      word_q [$];
    int         done_q [$];

    vec_t vecs [11];

    always @(posedge clk) cyc <= cyc + 1;

    // Logs per-cycle outputs (cycle 1 = the cycle after the start edge) and
    // every word actually accepted by this block.
    always @(negedge clk) begin
        if (armed) begin
            mon_r = cyc - e_cyc + 1;
            if (mon_r >= 0 && mon_r < 64) begin
                req_hist[mon_r]  = bus.bus_req;
                addr_hist[mon_r] = bus.bus_is_addr;
                data_hist[mon_r] = bus.bus_data;
                band_hist[mon_r] = band;
                busy_hist[mon_r] = busy;
                done_hist[mon_r] = done;
            end
            if (bus.bus_req && bus.bus_ack && !abort && !reset)
                word_q.push_back({bus.bus_is_addr, bus.bus_data, band});
            if (done)
                done_q.push_back(mon_r);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic restoreInputs();
        for (int i = 0; i < N_CH; i++) begin
            ch_addr[i*DATA_W +: DATA_W] = 8'(8'h21 + i);
            ch_data[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
        end
    endtask

    // Runs one sweep record: pulses start, then for a fixed window drives
    // bus_ack, mid-sweep pokes, abort and reset at their scheduled cycles.
    task automatic applyStimulus(input vec_t v);
        int r;
        word_q.delete();
        done_q.delete();
        for (int i = 0; i < 64; i++) begin
            req_hist[i] = 1'bx; addr_hist[i] = 1'bx; data_hist[i] = 'x;
            band_hist[i] = 'x; busy_hist[i] = 1'bx; done_hist[i] = 1'bx;
        end
        restoreInputs();
        ch_mask = v.mask;
        bus.bus_ack = 1'b1;
        start = 1'b1;
        e_cyc = cyc + 1;
        armed = 1'b1;
        for (int k = 0; k < WINDOW; k++) begin
            @(posedge clk);
            #2;
            r = cyc - e_cyc + 1;
            start = (r == v.poke_at);
            if (r == v.poke_at) ch_data[7:0] = 8'h99;
            bus.bus_ack = !(v.stall_len > 0 && r >= v.stall_at && r < v.stall_at + v.stall_len);
            abort = (r == v.abort_at);
            reset = (r == v.reset_at);
        end
        @(posedge clk);
        #2;
        armed = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        bus.bus_ack = 1'b1;
    endtask

    task automatic checkSweep(input vec_t v);
        word_t exp_q [$];
        for (int ch = 0; ch < N_CH; ch++) begin
            if (v.mask[ch]) begin
                exp_q.push_back({1'b1, 8'(8'h21 + ch), 3'(ch)});
                exp_q.push_back({1'b0, 8'(8'h10 + ch), 3'(ch)});
            end
        end
        checkOutput({v.name, " word count"}, word_q.size(), v.exp_words);
        for (int i = 0; i < v.exp_words && i < word_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s word %0d {addr,data,band}", v.name, i),
                        int'(word_q[i]), int'(exp_q[i]));
        checkOutput({v.name, " done pulses"}, done_q.size(), (v.exp_done > 0) ? 1 : 0);
        if (v.exp_done > 0 && done_q.size() > 0)
            checkOutput({v.name, " done cycle"}, done_q[0], v.exp_done);
        checkOutput({v.name, " busy in cycle 1"}, int'(busy_hist[1]), 1);
        if (v.exp_done > 0) begin
            checkOutput({v.name, " busy on done"}, int'(busy_hist[v.exp_done]), 1);
            checkOutput({v.name, " busy after done"}, int'(busy_hist[v.exp_done + 1]), 0);
        end
        if (v.stall_len > 0) begin
            for (int r = v.stall_at; r <= v.stall_at + v.stall_len; r++) begin
                checkOutput($sformatf("%s stall req c%0d", v.name, r), int'(req_hist[r]), 1);
                checkOutput($sformatf("%s stall is_addr c%0d", v.name, r), int'(addr_hist[r]), 1);
                checkOutput($sformatf("%s stall data c%0d", v.name, r), int'(data_hist[r]), int'(v.stall_word));
            end
        end
        for (int r = 1; r < WINDOW; r++) begin
            if (v.req_low[r])
                checkOutput($sformatf("%s bus_req low c%0d", v.name, r), int'(req_hist[r]), 0);
        end
        if (v.idle_at > 0) begin
            checkOutput({v.name, " idle bus_req"}, int'(req_hist[v.idle_at]), 0);
            checkOutput({v.name, " idle busy"}, int'(busy_hist[v.idle_at]), 0);
            checkOutput({v.name, " idle done"}, int'(done_hist[v.idle_at]), 0);
            if (v.all_zero) begin
                checkOutput({v.name, " zero is_addr"}, int'(addr_hist[v.idle_at]), 0);
                checkOutput({v.name, " zero bus_data"}, int'(data_hist[v.idle_at]), 0);
                checkOutput({v.name, " zero band"}, int'(band_hist[v.idle_at]), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          name            mask       st  sl  sword poke ab  rs  wds done idle zero req_low
        vecs[0]  = '{"full",        6'b111111, 0,  0,  8'h0, 0,   0,  0,  12, 20,  0,  0,  32'h0};
        vecs[1]  = '{"sparse",      6'b100101, 0,  0,  8'h0, 0,   0,  0,  6,  11,  0,  0,  32'h0000_0492};
        vecs[2]  = '{"backpressure",6'b111111, 5,  3,  8'h22,0,   0,  0,  12, 23,  0,  0,  32'h0};
        vecs[3]  = '{"snapshot",    6'b111111, 0,  0,  8'h0, 2,   0,  0,  12, 20,  0,  0,  32'h0};
        vecs[4]  = '{"empty",       6'b000000, 0,  0,  8'h0, 0,   0,  0,  0,  2,   0,  0,  32'hFFFF_FFFE};
        vecs[5]  = '{"abort ch3",   6'b111111, 0,  0,  8'h0, 0,   12, 0,  7,  0,   13, 0,  32'h0};
        vecs[6]  = '{"reset ch3",   6'b111111, 0,  0,  8'h0, 0,   0,  12, 7,  0,   13, 1,  32'h0};
        vecs[7]  = '{"full again",  6'b111111, 0,  0,  8'h0, 0,   0,  0,  12, 20,  0,  0,  32'h0};
        vecs[8]  = '{"last only",   6'b100000, 0,  0,  8'h0, 0,   0,  0,  2,  5,   0,  0,  32'h0};
        vecs[9]  = '{"abort done",  6'b000001, 0,  0,  8'h0, 0,   5,  0,  2,  5,   0,  0,  32'h0};
        vecs[10] = '{"abort addr0", 6'b111111, 0,  0,  8'h0, 0,   2,  0,  0,  0,   3,  0,  32'h0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ch_mask = '0;
        bus.bus_ack = 1'b0;
        restoreInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset bus_req", int'(bus.bus_req), 0);
        checkOutput("reset bus_is_addr", int'(bus.bus_is_addr), 0);
        checkOutput("reset bus_data", int'(bus.bus_data), 0);
        checkOutput("reset band", int'(band), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.bus_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        for (int i = 0; i < 11; i++) begin
            $display("[TB] running %s", vecs[i].name);
            applyStimulus(vecs[i]);
            checkSweep(vecs[i]);
            repeat (2) @(posedge clk);
            #2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rtc_data_sequencer.md
# rtc_data_sequencer

Parametrised sequencer that transfers a snapshot of N_CH RTC register values (seconds, minutes, hours, day, month, year, …) to the RTC bus controller. For each enabled channel it sends an address phase, then a data phase, over a valid/ack handshake. It replaces the static channel-select mux with automatic, masked, back-pressured iteration. It sits between the time-keeping/user-edit registers and the RTC bus interface FSM.

## Interface
- DATA_W, 8, width of address and data words
- N_CH, 6, number of channels (at least 1)
- IDX_W, $clog2(N_CH) (minimum 1), width of `band`

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  synchronous cancel of a sweep in progress
- ch_mask  in  N_CH  per-channel enable; bit i = channel i
- ch_addr  in  N_CH*DATA_W  flat RTC register addresses; channel i at [i*DATA_W +: DATA_W]
- ch_data  in  N_CH*DATA_W  flat register values, same packing
- bus_req  out  1  word valid toward the bus controller
- bus_ack  in  1  bus controller accepts the current word
- bus_is_addr  out  1  1 = address phase, 0 = data phase
- bus_data  out  DATA_W  current word
- band  out  IDX_W  index of the channel being transferred
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a sweep completes normally

## Operation
- States: IDLE, SCAN, ADDR, DATA, DONE.
- **IDLE**
  - If start=1, capture ch_mask, ch_addr and ch_data into internal snapshot registers, set the scan pointer to 0, go to SCAN.
  - All transfers use the snapshot. Input changes during a sweep have no effect.
- **SCAN** (exactly one cycle)
  - Priority-find the lowest enabled snapshot-mask channel with index ≥ pointer.
  - If one is found: band ← that index, go to ADDR.
  - If none is found: go to DONE.
- **ADDR**
  - Drives bus_req=1, bus_is_addr=1, bus_data=snap_addr[band].
  - On an edge with bus_ack=1, go to DATA.
- **DATA**
  - Drives bus_req=1, bus_is_addr=0, bus_data=snap_data[band].
  - On an edge with bus_ack=1, set pointer ← band+1 and go to SCAN.
  - If band = N_CH-1, the next SCAN goes to DONE; the pointer never wraps.
- **DONE**: done=1 for one cycle, then IDLE.
- **Handshake**
  - A word transfers on an edge where bus_req and bus_ack are both 1.
  - While bus_req=1 and bus_ack=0, bus_data, bus_is_addr and band hold stable.
  - bus_ack is ignored when bus_req=0.
- **start**: ignored while busy; a start asserted in DONE is ignored.
- **abort**
  - In SCAN/ADDR/DATA: next state IDLE, no done pulse, bus_req low next cycle.
  - abort has priority over bus_ack on the same edge; that word is treated as not accepted by this block.
  - abort in IDLE or DONE has no effect; a DONE cycle still pulses done.
- **reset** has priority over everything and may be asserted mid-sweep.
  - Result: state IDLE, bus_req=0, bus_is_addr=0, bus_data=0, band=0, busy=0, done=0, snapshot and pointer cleared.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational paths from input to output.
- Start sampled at edge E:
  - SCAN occupies cycle E+1.
  - The first ADDR word is valid from cycle E+2.
- With bus_ack held 1:
  - Each channel costs 3 cycles: ADDR, DATA, SCAN.
  - ADDR→DATA has no bubble.
  - DATA→next ADDR has one bubble cycle with bus_req=0.
- Sweep latency with bus_ack held 1 and K enabled channels: done high in cycle E+2+3K.
- Each cycle with bus_ack=0 in ADDR or DATA adds one cycle.
- A new start is accepted at the earliest on the IDLE cycle after DONE.

## Test plan
1. **Full sweep, no backpressure.** N_CH=6, mask=6'b111111, addresses 0x21..0x26, data 0x10..0x15, bus_ack=1.
   - Required: 12 words in order (0x21, A), (0x10, D), …, (0x26, A), (0x15, D).
   - band steps 0..5; done high exactly in cycle E+20.
2. **Sparse mask.** mask=6'b100101.
   - Required: only channels 0, 2, 5 are transferred; done in cycle E+11.
   - bus_req is low in cycles E+1, E+4, E+7 and E+10.
3. **Backpressure.** Hold bus_ack=0 for 3 cycles during channel 1 ADDR.
   - Required: bus_req=1, bus_is_addr=1 and bus_data=0x22 stable for 4 cycles; then DATA 0x11; done delayed by exactly 3 cycles versus scenario 1.
4. **Snapshot and start immunity.** Change ch_data[0] from 0x10 to 0x99 and pulse start during channel 0 ADDR.
   - Required: the channel 0 DATA word is 0x10; no second sweep starts; exactly one done pulse.
5. **Empty mask.** mask=0, then start.
   - Required: bus_req is never asserted; busy is high for cycles E+1..E+2; done high in cycle E+2.
6. **Abort and reset.** abort together with bus_ack=1 during channel 3 DATA.
   - Required: IDLE next cycle, bus_req=0, busy=0, no done pulse.
   - Repeat with reset instead of abort: all outputs are 0 the following cycle. A subsequent start then completes the full 12-word sweep normally.
